mem_arbiter: RTL

Two-port arbiter sharing the single external memory port between the instruction cache (requester c0) and the data cache (requester c1).
- Grants one whole transaction at a time: request, then either all write-data beats or all read-response beats.
- Routes read responses back to the owner.
- Round-robin when both caches miss together.
- Sits between the two cache instances and the memory interface at the top of the processor.

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one external memory port between the instruction cache
//            (requester c0) and the data cache (requester c1). The port is
//            granted one whole transaction at a time (request, then either
//            all write beats or all read beats). Read beats are routed back
//            to the owner. Simultaneous misses are served round-robin.
// Ports    : clk, reset (async, active low)
//            cX_req_*   : request/write-data channel from cache X (X = 0, 1)
//            cX_resp_*  : read-beat channel back to cache X
//            mem_req_*  : request/write-data channel to memory
//            mem_resp_* : read-beat channel from memory
//            err_stray  : sticky, set by a memory read beat outside RDATA
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int BEATS  = 4
) (
  input  logic                clk,
  input  logic                reset,
  // icache requester
  input  logic                c0_req_val,
  output logic                c0_req_rdy,
  input  logic [ADDR_W-1:0]   c0_req_addr,
  input  logic                c0_req_rw,
  input  logic                c0_req_data_valid,
  output logic                c0_req_data_ready,
  input  logic [DATA_W-1:0]   c0_req_data_bits,
  input  logic [DATA_W/8-1:0] c0_req_data_mask,
  output logic                c0_resp_val,
  output logic [DATA_W-1:0]   c0_resp_data,
  // dcache requester
  input  logic                c1_req_val,
  output logic                c1_req_rdy,
  input  logic [ADDR_W-1:0]   c1_req_addr,
  input  logic                c1_req_rw,
  input  logic                c1_req_data_valid,
  output logic                c1_req_data_ready,
  input  logic [DATA_W-1:0]   c1_req_data_bits,
  input  logic [DATA_W/8-1:0] c1_req_data_mask,
  output logic                c1_resp_val,
  output logic [DATA_W-1:0]   c1_resp_data,
  // memory side
  output logic                mem_req_val,
  input  logic                mem_req_rdy,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic                mem_req_rw,
  output logic                mem_req_data_valid,
  input  logic                mem_req_data_ready,
  output logic [DATA_W-1:0]   mem_req_data_bits,
  output logic [DATA_W/8-1:0] mem_req_data_mask,
  input  logic                mem_resp_val,
  input  logic [DATA_W-1:0]   mem_resp_data,
  output logic                err_stray
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WDATA = 2'd2,
    S_RDATA = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            rr_last_q, rr_last_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic            err_stray_q, err_stray_d;

  // Owner-selected request fields. These only reach memory when the
  // corresponding valid is raised, so they can be muxed unconditionally.
  logic [ADDR_W-1:0]   own_addr;
  logic                own_rw;
  logic                own_dv;
  logic [DATA_W-1:0]   own_bits;
  logic [DATA_W/8-1:0] own_mask;

  assign own_addr = owner_q ? c1_req_addr       : c0_req_addr;
  assign own_rw   = owner_q ? c1_req_rw         : c0_req_rw;
  assign own_dv   = owner_q ? c1_req_data_valid : c0_req_data_valid;
  assign own_bits = owner_q ? c1_req_data_bits  : c0_req_data_bits;
  assign own_mask = owner_q ? c1_req_data_mask  : c0_req_data_mask;

  assign mem_req_addr      = own_addr;
  assign mem_req_rw        = own_rw;
  assign mem_req_data_bits = own_bits;
  assign mem_req_data_mask = own_mask;

  // Read data is broadcast; only the valids are steered to the owner.
  assign c0_resp_data = mem_resp_data;
  assign c1_resp_data = mem_resp_data;

  assign err_stray = err_stray_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      rr_last_q   <= 1'b1;  // makes c0 the winner of the first tie
      beat_q      <= '0;
      err_stray_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      beat_q      <= beat_d;
      err_stray_q <= err_stray_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    beat_d      = beat_q;
    err_stray_d = err_stray_q | (mem_resp_val & (state_q != S_RDATA));

    mem_req_val        = 1'b0;
    mem_req_data_valid = 1'b0;
    c0_req_rdy         = 1'b0;
    c1_req_rdy         = 1'b0;
    c0_req_data_ready  = 1'b0;
    c1_req_data_ready  = 1'b0;
    c0_resp_val        = 1'b0;
    c1_resp_val        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Grant is registered: no requester sees rdy in IDLE, which keeps
        // cX_req_val off any combinational path to mem_req_val.
        if (c0_req_val || c1_req_val) begin
          state_d = S_REQ;
          if (c0_req_val && c1_req_val) begin
            owner_d = ~rr_last_q;
          end else begin
            owner_d = c1_req_val;
          end
        end
      end

      S_REQ: begin
        mem_req_val = 1'b1;
        c0_req_rdy  = ~owner_q & mem_req_rdy;
        c1_req_rdy  =  owner_q & mem_req_rdy;
        if (mem_req_rdy) begin
          state_d = own_rw ? S_WDATA : S_RDATA;
          beat_d  = '0;
        end
      end

      S_WDATA: begin
        mem_req_data_valid = own_dv;
        c0_req_data_ready  = ~owner_q & mem_req_data_ready;
        c1_req_data_ready  =  owner_q & mem_req_data_ready;
        if (own_dv && mem_req_data_ready) begin
          if (beat_q == LAST_BEAT) begin
            state_d   = S_IDLE;
            beat_d    = '0;
            rr_last_d = owner_q;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end

      S_RDATA: begin
        c0_resp_val = mem_resp_val & ~owner_q;
        c1_resp_val = mem_resp_val &  owner_q;
        if (mem_resp_val) begin
          if (beat_q == LAST_BEAT) begin
            state_d   = S_IDLE;
            beat_d    = '0;
            rr_last_d = owner_q;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
